// File: rtl/axis_eth_framer.sv
// Byte-wide AXI-Stream Ethernet framer: prepends preamble and SFD to each frame and
// zero-pads short frames up to the minimum length.
module axis_eth_framer #(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter logic [7:0]  SFD_BYTE        = 8'hD5,
    parameter int unsigned MIN_FRAME_BYTES = 60
) (
    input  logic       clk,
    input  logic       sreset,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    input  logic       axis_o_tready,
    output logic       axis_o_tvalid,
    output logic       axis_o_tlast,
    output logic [7:0] axis_o_tdata
);

    localparam logic [3:0] PreLast  = 4'(PREAMBLE_BYTES - 1);
    localparam logic [8:0] MinLen   = 9'(MIN_FRAME_BYTES);
    localparam logic [8:0] MinLenM1 = MinLen - 9'd1;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StPay,
        StPad
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pre_ctr_q, pre_ctr_d;
    logic [7:0] len_ctr_q, len_ctr_d;

    logic [8:0] len_inc;
    logic       len_done;
    logic       len_sat;
    logic [7:0] len_next;
    logic       pad_last;

    // Length is compared 9 bits wide so MIN_FRAME_BYTES=255 and 0 both behave.
    assign len_inc  = {1'b0, len_ctr_q} + 9'd1;
    assign len_done = (len_inc >= MinLen);
    assign len_sat  = ({1'b0, len_ctr_q} >= MinLen);
    assign len_next = len_sat ? len_ctr_q : len_inc[7:0];
    assign pad_last = ({1'b0, len_ctr_q} == MinLenM1);

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q   <= StIdle;
            pre_ctr_q <= 4'd0;
            len_ctr_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pre_ctr_q <= pre_ctr_d;
            len_ctr_q <= len_ctr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_ctr_d = pre_ctr_q;
        len_ctr_d = len_ctr_q;
        unique case (state_q)
            StIdle: begin
                if (axis_i_tvalid) begin
                    state_d   = StPre;
                    pre_ctr_d = 4'd0;
                    len_ctr_d = 8'd0;
                end
            end
            StPre: begin
                if (axis_o_tready) begin
                    pre_ctr_d = pre_ctr_q + 4'd1;
                    if (pre_ctr_q == PreLast) begin
                        state_d = StSfd;
                    end
                end
            end
            StSfd: begin
                if (axis_o_tready) begin
                    state_d = StPay;
                end
            end
            StPay: begin
                if (axis_i_tvalid && axis_o_tready) begin
                    len_ctr_d = len_next;
                    if (axis_i_tlast) begin
                        state_d = len_done ? StIdle : StPad;
                    end
                end
            end
            StPad: begin
                if (axis_o_tready) begin
                    len_ctr_d = len_next;
                    if (pad_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced idle while reset is held so nothing leaks out mid-abandon.
    always_comb begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = 8'h00;
        if (!sreset) begin
            unique case (state_q)
                StIdle: ;
                StPre: begin
                    axis_o_tvalid = 1'b1;
                    axis_o_tdata  = 8'h55;
                end
                StSfd: begin
                    axis_o_tvalid = 1'b1;
                    axis_o_tdata  = SFD_BYTE;
                end
                StPay: begin
                    axis_i_tready = axis_o_tready;
                    axis_o_tvalid = axis_i_tvalid;
                    axis_o_tdata  = axis_i_tdata;
                    axis_o_tlast  = axis_i_tlast && len_done;
                end
                StPad: begin
                    axis_o_tvalid = 1'b1;
                    axis_o_tlast  = pad_last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axis_eth_framer.md
# axis_eth_framer

Byte-wide AXI-Stream stage that turns a raw Ethernet frame (destination MAC through FCS) into a line-ready frame. It prepends preamble and SFD and zero-pads short frames to the minimum length. It sits directly upstream of the inter-packet gap spacer in the transmit path. Its output stream is one continuous burst per frame, with `tlast` on the final byte, which the spacer uses to time the gap.

## Interface
- `PREAMBLE_BYTES`, default 7: number of 0x55 bytes emitted before the SFD; legal range 1..15.
- `SFD_BYTE`, default 8'hD5: start-of-frame delimiter value.
- `MIN_FRAME_BYTES`, default 60: minimum payload bytes emitted per frame, with 0x00 padding; 0 disables padding; legal range 0..255.
- `clk`, input, 1: sole clock; all logic rising-edge.
- `sreset`, input, 1: reset, synchronous, active-high.
- `axis_i_tready`, output, 1: input accept.
- `axis_i_tvalid`, input, 1: input byte valid.
- `axis_i_tlast`, input, 1: last byte of input frame.
- `axis_i_tdata`, input, 8: input byte.
- `axis_o_tready`, input, 1: downstream accept.
- `axis_o_tvalid`, output, 1: output byte valid.
- `axis_o_tlast`, output, 1: last byte of output frame.
- `axis_o_tdata`, output, 8: output byte.

## Operation
- **States:** IDLE, PRE, SFD, PAY, PAD. These are held in a 3-bit state register.
- **Counters:**
  - `pre_ctr` is 4 bits.
  - `len_ctr` is 8 bits and counts payload bytes emitted, with pad bytes included.
  - `len_ctr` saturates at `MIN_FRAME_BYTES` and never wraps, so frames longer than 255 bytes are handled.
- **IDLE:**
  - Outputs: `o_tvalid=0`, `i_tready=0`.
  - When `i_tvalid=1`, go to PRE and clear `pre_ctr` and `len_ctr`.
  - The input byte is not consumed in IDLE.
- **PRE:**
  - Outputs: `o_tvalid=1`, `o_tdata=0x55`, `o_tlast=0`, `i_tready=0`.
  - On each output handshake, `pre_ctr++`.
  - On the handshake with `pre_ctr==PREAMBLE_BYTES-1`, go to SFD.
- **SFD:**
  - Outputs: `o_tvalid=1`, `o_tdata=SFD_BYTE`, `o_tlast=0`, `i_tready=0`.
  - On handshake, go to PAY.
- **PAY:** pass-through. Outputs:
  - `o_tvalid=i_tvalid`
  - `i_tready=o_tready`
  - `o_tdata=i_tdata`
  - `o_tlast=i_tlast && (len_ctr+1 >= MIN_FRAME_BYTES)`
- **PAY handshakes:**
  - On each handshake, `len_ctr` increments (saturating).
  - On a handshake with `i_tlast=1`:
    - if `len_ctr+1 >= MIN_FRAME_BYTES`, go to IDLE;
    - otherwise go to PAD.
- **PAD:**
  - Outputs: `o_tvalid=1`, `o_tdata=0x00`, `i_tready=0`, `o_tlast=(len_ctr==MIN_FRAME_BYTES-1)`.
  - On each handshake, `len_ctr++`.
  - On the handshake with `o_tlast`, go to IDLE.
- **AXIS compliance:**
  - Once asserted, `o_tvalid`, `o_tdata` and `o_tlast` are stable until handshake in PRE, SFD and PAD.
  - In PAY they are stable by inheritance from the upstream source.
  - No combinational path from `o_tready` to `o_tvalid`.
- **Input bubbles:** if `i_tvalid` drops mid-frame in PAY, `o_tvalid` drops too. The block neither pads nor times out.
- **Output frame length** = `PREAMBLE_BYTES + 1 + max(N, MIN_FRAME_BYTES)`, where N is the input frame length.

## Timing
- **Reset:**
  - state = IDLE, counters = 0.
  - Outputs during and after reset: `o_tvalid=0`, `i_tready=0`; `o_tlast=0` and `o_tdata=0x00` (don't-care but driven).
- **Reset mid-frame:**
  - The frame is abandoned immediately and no `tlast` is emitted.
  - Any remaining input bytes of that frame are treated as a new frame after reset.
  - Clearing upstream is the system's job.
- **Latency:**
  - The first PRE byte is valid the cycle after `i_tvalid` rises in IDLE.
  - The first payload byte is accepted no earlier than `PREAMBLE_BYTES+2` cycles after that rise.
- **Throughput:**
  - One byte per cycle when `o_tready=1` throughout.
  - Zero idle cycles between PRE, SFD, PAY and PAD.
  - One IDLE cycle minimum between frames (PAY/PAD→IDLE→PRE).
- **Single-byte input frame** (`i_tlast` on first byte, MIN=60): PAY emits 1 byte with `o_tlast=0`, then PAD emits 59 bytes.
- **Frame exactly `MIN_FRAME_BYTES` long:** `o_tlast` is on the last payload byte and PAD is never entered.
- **`MIN_FRAME_BYTES=0`:** PAD is unreachable; `o_tlast` equals `i_tlast` in PAY.
- **Back-pressure in PRE, SFD or PAD:** the counter holds and the byte is repeated unchanged.

## Test plan
- **Basic frame:** defaults, `o_tready=1`, 64-byte input 0x01..0x40.
  - Expect 7×0x55, 0xD5, then 0x01..0x40; `tlast` on 0x40.
  - 72 output bytes in 72 consecutive cycles, starting the cycle after `i_tvalid` rises.
- **Short frame:** 1-byte input 0xAB.
  - Expect 7×0x55, 0xD5, 0xAB, 59×0x00; `tlast` only on the final 0x00; 68 bytes total.
- **Boundary lengths:**
  - 60-byte input: `tlast` on input byte 60, zero pad bytes.
  - 59-byte input: exactly one 0x00 pad carrying `tlast`.
  - 300-byte input: no pad; counter saturation causes no early `tlast`.
- **Back-pressure:** random `o_tready` (50%) plus random input `tvalid` gaps across 20 frames of lengths 1..100.
  - Output byte sequence matches the reference model.
  - `tdata`/`tlast` never change while `o_tvalid && !o_tready`.
  - `i_tready` is never high outside PAY.
- **Reset mid-operation:** assert `sreset` for 1 cycle during PRE (after 3 bytes) and again during PAD.
  - Next cycle: `o_tvalid=0`, `i_tready=0`.
  - The next frame starts with a full 7-byte preamble.
- **Parameter variants:**
  - `PREAMBLE_BYTES=1`, `MIN_FRAME_BYTES=0`, 3-byte input: 0x55, 0xD5, 3 bytes, `tlast` on third.
  - `MIN_FRAME_BYTES=4`, 2-byte input: two pad bytes.
